mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide responder that owns the architectural HI/LO registers of the MIPS core.
- The datapath/ALU issues MULT, MULTU, DIV, DIVU, MTHI and MTLO requests to it; MFHI and MFLO read its hi/lo outputs.
- The control FSM stalls MFHI/MFLO and new requests while busy is high.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mdu_negate.sv | 14 +
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU/decoder opcode codes, multiply/divide FSM states
// and the default datapath width.
package cpu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [6:0] {
    OP_DIV   = 7'd7,
    OP_DIVU  = 7'd8,
    OP_MTHI  = 7'd11,
    OP_MTLO  = 7'd12,
    OP_MULT  = 7'd13,
    OP_MULTU = 7'd14
  } opcode_decode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage : cpu_pkg

// File: rtl/mdu_negate.sv
// Conditional two's-complement. The carry-in allows two instances to be chained
// into a double-width negate (upper half takes carry = lower half was zero).
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic             cin,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = en ? (~value + WIDTH'(cin)) : value;

endmodule : mdu_negate

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide on magnitudes, with a final sign-fix cycle.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     opm_q, opm_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 req_div_c, req_mul_c, req_signed_c;
  logic [WIDTH-1:0]     a_mag_c, b_mag_c;
  logic [WIDTH:0]       shift_c, trial_c, sum_c;
  logic                 fits_c;
  logic [WIDTH-1:0]     addend_c;
  logic [WIDTH-1:0]     hi_raw_c, lo_raw_c, hi_fix_c, lo_fix_c;
  logic                 hi_cin_c;

  assign req_div_c    = (op == OP_DIV)  || (op == OP_DIVU);
  assign req_mul_c    = (op == OP_MULT) || (op == OP_MULTU);
  assign req_signed_c = (op == OP_DIV)  || (op == OP_MULT);

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en       (req_signed_c & a[WIDTH-1]),
    .cin      (1'b1),
    .value    (a),
    .result_c (a_mag_c)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en       (req_signed_c & b[WIDTH-1]),
    .cin      (1'b1),
    .value    (b),
    .result_c (b_mag_c)
  );

  // Restoring divide step: shift in the next dividend bit, try the subtract.
  assign shift_c  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign trial_c  = shift_c - {1'b0, opm_q};
  assign fits_c   = rem_q[WIDTH] || (shift_c >= {1'b0, opm_q});

  // Shift-add multiply step: conditionally add multiplicand into the upper half.
  assign addend_c = acc_q[0] ? opm_q : '0;
  assign sum_c    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_c};

  // Sign fix; for products the upper half absorbs the carry out of the lower half.
  assign lo_raw_c = acc_q[WIDTH-1:0];
  assign hi_raw_c = is_div_q ? rem_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
  assign hi_cin_c = is_div_q || (lo_raw_c == '0);

  mdu_negate #(.WIDTH(WIDTH)) u_neg_lo (
    .en       (neg_lo_q),
    .cin      (1'b1),
    .value    (lo_raw_c),
    .result_c (lo_fix_c)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_hi (
    .en       (neg_hi_q),
    .cin      (hi_cin_c),
    .value    (hi_raw_c),
    .result_c (hi_fix_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opm_d    = opm_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MTHI) hi_d = a;
          if (op == OP_MTLO) lo_d = a;
          if (req_div_c || req_mul_c) begin
            is_div_d = req_div_c;
            opm_d    = req_div_c ? b_mag_c : a_mag_c;
            acc_d    = {{WIDTH{1'b0}}, (req_div_c ? a_mag_c : b_mag_c)};
            rem_d    = '0;
            neg_lo_d = req_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = req_signed_c & (req_div_c ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
            cnt_d    = CNT_W'(WIDTH - 1);
            busy_d   = 1'b1;
            state_d  = RUN;
            // Divide by zero: preload the fixed result and skip the iterations.
            if (req_div_c && (b == '0)) begin
              acc_d    = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              rem_d    = {1'b0, a};
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
              state_d  = FIX;
            end
          end
        end
      end

      RUN: begin
        if (is_div_q) begin
          rem_d = fits_c ? trial_c : shift_c;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], fits_c};
        end else begin
          acc_d = {sum_c, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      FIX: begin
        hi_d    = hi_fix_c;
        lo_d    = lo_fix_c;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opm_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opm_q    <= opm_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations against an arithmetic HI/LO reference model.
module tb_mult_div_unit;
  import cpu_pkg::*;

  localparam int unsigned W = 32;
  localparam int ITER_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [6:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: updates m_hi/m_lo and returns edges until the result lands (0 = immediate).
  task automatic model(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    longint      sx, sy, q, rm;
    logic [63:0] r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lat = 0;
    case (o)
      OP_MTHI: m_hi = x;
      OP_MTLO: m_lo = x;
      OP_MULT: begin
        r = 64'(sx * sy);
        m_hi = r[63:32]; m_lo = r[31:0]; lat = ITER_LAT;
      end
      OP_MULTU: begin
        r = {32'b0, x} * {32'b0, y};
        m_hi = r[63:32]; m_lo = r[31:0]; lat = ITER_LAT;
      end
      OP_DIV, OP_DIVU: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x; lat = 1;
        end else if (o == OP_DIV) begin
          q = sx / sy; rm = sx % sy;
          r = 64'(q);  m_lo = r[31:0];
          r = 64'(rm); m_hi = r[31:0];
          lat = ITER_LAT;
        end else begin
          m_lo = x / y; m_hi = x % y; lat = ITER_LAT;
        end
      end
      default: lat = 0;
    endcase
  endtask

  // Issue one request; optionally pulse a DIVU request n cycles into the run.
  task automatic do_op(input string tag, input logic [6:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int ignore_at = -1);
    int          lat, n, busy_n;
    logic        held;
    logic [31:0] ph, pl;
    ph = m_hi; pl = m_lo;
    model(o, x, y, lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 7'($urandom); a = $urandom; b = $urandom;
    if (lat == 0) begin
      check({tag, ":busy"}, 64'(busy), 64'(0));
      check({tag, ":done"}, 64'(done), 64'(0));
      check({tag, ":hi"}, 64'(hi), 64'(m_hi));
      check({tag, ":lo"}, 64'(lo), 64'(m_lo));
    end else begin
      check({tag, ":busy_at_accept"}, 64'(busy), 64'(1));
      check({tag, ":done_at_accept"}, 64'(done), 64'(0));
      busy_n = busy ? 1 : 0;
      n = 0;
      held = 1'b1;
      while (!done && n < 2 * ITER_LAT) begin
        @(negedge clk);
        if (n == ignore_at) begin
          start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        end
        @(posedge clk); #1;
        start = 1'b0;
        n++;
        if (busy) busy_n++;
        if (!done && (hi !== ph || lo !== pl)) held = 1'b0;
      end
      check({tag, ":latency"}, 64'(n), 64'(lat));
      check({tag, ":busy_cycles"}, 64'(busy_n), 64'(lat));
      check({tag, ":hold"}, 64'(held), 64'(1));
      check({tag, ":hi"}, 64'(hi), 64'(m_hi));
      check({tag, ":lo"}, 64'(lo), 64'(m_lo));
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
    if ($urandom_range(2) == 0) return $urandom_range(255);
    return $urandom;
  endfunction

  initial begin
    logic [6:0] ops [7] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, 7'd3};
    int seen;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("reset:busy", 64'(busy), 64'(0));
    check("reset:done", 64'(done), 64'(0));
    check("reset:hi", 64'(hi), 64'(0));
    check("reset:lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max:hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg:lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2:hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf:lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    do_op("divu_zero", OP_DIVU, 32'h1234, 32'd0);
    do_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0);
    do_op("mthi", OP_MTHI, 32'hCAFE_F00D, 32'd0);
    do_op("mtlo", OP_MTLO, 32'h1, 32'd0);
    do_op("bad_op", 7'd3, 32'h5555_5555, 32'h2);
    do_op("ignore_mid_run", OP_MULTU, 32'd5, 32'd6, 10);
    check("ignore_mid_run:lo_const", 64'(lo), 64'd30);

    for (int i = 0; i < 48; i++) begin
      logic [6:0] o;
      o = ops[$urandom_range(6)];
      do_op($sformatf("rand%0d_op%0d", i, o), o, pick_operand(), pick_operand());
    end

    // Reset during a run: everything clears at once and no done follows.
    do_op("pre_reset_mthi", OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset:busy", 64'(busy), 64'(0));
    check("midreset:done", 64'(done), 64'(0));
    check("midreset:hi", 64'(hi), 64'(0));
    check("midreset:lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * ITER_LAT) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midreset:no_activity", 64'(seen), 64'(0));
    check("midreset:lo_after", 64'(lo), 64'(0));

    do_op("post_reset_mult", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    @(posedge clk); #1;
    check("final:done_low", 64'(done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mult_div_unit
